// File: rtl/la_tbuf_arb_if.sv
// Requester-side bundle for la_tbuf_arb: level requests in; grant, output enable and status out.
interface la_tbuf_arb_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned OwnerW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]      req;
  logic [N-1:0]      gnt;
  logic [N-1:0]      oe;
  logic [OwnerW-1:0] owner;
  logic              busy;
  logic              tout;

  modport master (output req, input gnt, oe, owner, busy, tout);
  modport slave  (input req, output gnt, oe, owner, busy, tout);
endinterface

// File: rtl/la_tbuf_arb.sv
// Round-robin owner arbiter for a shared tristate net, with a dead-time between owners.
// Define LA_TBUF_ARB_TIMEOUT_EN to force release after MAXHOLD cycles of ownership.
module la_tbuf_arb #(
  parameter int unsigned N       = 4,
  parameter int unsigned TURN    = 1,
  parameter int unsigned MAXHOLD = 16,
  parameter              PROP    = "DEFAULT"
) (
  input  logic         clk_i,
  input  logic         rst_i,
  la_tbuf_arb_if.slave bus_io
);
  localparam int unsigned OwnerW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 32 || TURN > 15 || MAXHOLD < 2 || MAXHOLD > 65535) begin : g_param_err
    $error("la_tbuf_arb (%s): parameter out of range", PROP);
  end

  typedef enum logic [1:0] {StIdle, StGrant, StOwn, StTurn} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [N-1:0]      oe_q, oe_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OwnerW-1:0] sel;
  logic              found;
  logic              owner_req;
  logic              rel;
`ifdef LA_TBUF_ARB_TIMEOUT_EN
  logic [15:0]       hold_q, hold_d;
  logic              tout_q, tout_d;
`endif

  assign owner_req = bus_io.req[owner_q];

  // Rotating priority search starting at ptr_q.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && bus_io.req[OwnerW'(idx)]) begin
        found = 1'b1;
        sel   = OwnerW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    oe_d    = oe_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
`ifdef LA_TBUF_ARB_TIMEOUT_EN
    hold_d  = hold_q;
    tout_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = N'(1) << sel;
          owner_d = sel;
          ptr_d   = (32'(sel) + 32'd1 == N) ? '0 : sel + OwnerW'(1);
        end
      end
      StGrant: begin
        if (owner_req) begin
          state_d = StOwn;
          oe_d    = gnt_q;
`ifdef LA_TBUF_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          // Bus never driven, so no turnaround is needed.
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      StOwn: begin
        if (!owner_req) begin
          rel = 1'b1;
`ifdef LA_TBUF_ARB_TIMEOUT_EN
        end else if (hold_q == 16'(MAXHOLD - 1)) begin
          rel    = 1'b1;
          tout_d = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
`endif
        end
        if (rel) begin
          gnt_d = '0;
          oe_d  = '0;
          if (TURN > 0) begin
            state_d = StTurn;
            cnt_d   = 4'(TURN - 1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      StTurn: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      oe_q    <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef LA_TBUF_ARB_TIMEOUT_EN
      hold_q  <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef LA_TBUF_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign bus_io.gnt   = gnt_q;
  assign bus_io.oe    = oe_q;
  assign bus_io.owner = owner_q;
  assign bus_io.busy  = (state_q != StIdle);
`ifdef LA_TBUF_ARB_TIMEOUT_EN
  assign bus_io.tout  = tout_q;
`else
  assign bus_io.tout  = 1'b0;
`endif

endmodule

// File: tb/tb_la_tbuf_arb.sv
// Scoreboard bench for la_tbuf_arb: three instances (TURN = 0, 1, 3) share one request stream
// and are checked against an event/time-based ownership model.
module tb_la_tbuf_arb;
  localparam int unsigned N = 4;
  localparam int MaxHold = 16;
`ifdef LA_TBUF_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       busy;
    logic       tout;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;

  always #5 clk = ~clk;

  la_tbuf_arb_if #(.N(N)) if0 ();
  la_tbuf_arb_if #(.N(N)) if1 ();
  la_tbuf_arb_if #(.N(N)) if2 ();
  assign if0.req = req;
  assign if1.req = req;
  assign if2.req = req;

  la_tbuf_arb #(.N(N), .TURN(0), .MAXHOLD(MaxHold), .PROP("DEFAULT")) u_t0 (
    .clk_i(clk), .rst_i(rst), .bus_io(if0));
  la_tbuf_arb #(.N(N), .TURN(1), .MAXHOLD(MaxHold), .PROP("DEFAULT")) u_t1 (
    .clk_i(clk), .rst_i(rst), .bus_io(if1));
  la_tbuf_arb #(.N(N), .TURN(3), .MAXHOLD(MaxHold), .PROP("DEFAULT")) u_t3 (
    .clk_i(clk), .rst_i(rst), .bus_io(if2));

  obs_t exp_q0[$];
  obs_t exp_q1[$];
  obs_t exp_q2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;

  // Model: holder = current grantee (-1 none), drv = bus being driven, free_at = first edge at
  // which a new arbitration may happen, ten = completed OWN cycles of the present tenure.
  int m_holder[3];
  bit m_drv[3];
  int m_ptr[3];
  int m_own[3];
  int m_free[3];
  int m_ten[3];
  bit m_tout[3];

  function automatic int turn_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  function automatic obs_t model_step(input int k, input logic [3:0] r, input logic rs,
                                      input int e);
    obs_t o;
    bit   drop;
    int   c;
    m_tout[k] = 1'b0;
    if (rs) begin
      m_holder[k] = -1; m_drv[k] = 0; m_ptr[k] = 0; m_own[k] = 0; m_free[k] = 0; m_ten[k] = 0;
    end else if (m_holder[k] >= 0 && !m_drv[k]) begin
      if (r[m_holder[k]]) begin
        m_drv[k] = 1; m_ten[k] = 0;
      end else begin
        m_holder[k] = -1; m_free[k] = e + 1;
      end
    end else if (m_holder[k] >= 0) begin
      drop = !r[m_holder[k]];
      if (!drop && TimeoutOn && m_ten[k] == MaxHold - 1) begin
        drop = 1; m_tout[k] = 1;
      end else if (!drop) begin
        m_ten[k]++;
      end
      if (drop) begin
        m_holder[k] = -1; m_drv[k] = 0; m_free[k] = e + 1 + turn_of(k);
      end
    end else if (e >= m_free[k] && r != 4'b0) begin
      for (int i = 0; i < int'(N); i++) begin
        c = (m_ptr[k] + i) % int'(N);
        if (r[c]) begin
          m_holder[k] = c;
          break;
        end
      end
      m_own[k] = m_holder[k];
      m_ptr[k] = (m_holder[k] + 1) % int'(N);
    end
    o.gnt   = (m_holder[k] >= 0) ? 4'(1 << m_holder[k]) : 4'b0;
    o.oe    = m_drv[k] ? 4'(1 << m_holder[k]) : 4'b0;
    o.owner = 2'(m_own[k]);
    o.busy  = (m_holder[k] >= 0) || (e + 1 < m_free[k]);
    o.tout  = m_tout[k];
    return o;
  endfunction

  task automatic step(input logic [3:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    exp_q0.push_back(model_step(0, r, rs, edge_n));
    exp_q1.push_back(model_step(1, r, rs, edge_n));
    exp_q2.push_back(model_step(2, r, rs, edge_n));
    edge_n++;
  endtask

  task automatic check(input int k, input obs_t a, input obs_t x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL outputs turn=%0d t=%0t: got gnt=%b oe=%b owner=%0d busy=%b tout=%b, want gnt=%b oe=%b owner=%0d busy=%b tout=%b",
               turn_of(k), $time, a.gnt, a.oe, a.owner, a.busy, a.tout,
               x.gnt, x.oe, x.owner, x.busy, x.tout);
    end
    n_cmp++;
    if (!$onehot0(a.oe) || ((a.oe & ~a.gnt) != 4'b0)) begin
      n_bad++;
      $display("FAIL oe_invariant turn=%0d t=%0t: got oe=%b gnt=%b, want oe one-hot0 and within gnt",
               turn_of(k), $time, a.oe, a.gnt);
    end
  endtask

  // Monitor: compares whatever the DUTs present one time step after each rising edge.
  initial begin
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        a = {if0.gnt, if0.oe, if0.owner, if0.busy, if0.tout};
        check(0, a, exp_q0.pop_front());
      end
      if (exp_q1.size() > 0) begin
        a = {if1.gnt, if1.oe, if1.owner, if1.busy, if1.tout};
        check(1, a, exp_q1.pop_front());
      end
      if (exp_q2.size() > 0) begin
        a = {if2.gnt, if2.oe, if2.owner, if2.busy, if2.tout};
        check(2, a, exp_q2.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] r;
    // Reset held with all requests up.
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    // Round robin on the TURN=1 instance: its owner releases after 3 OWN cycles.
    for (int i = 0; i < 60; i++) begin
      r = 4'b1111;
      if (m_drv[1] && m_ten[1] >= 2) r[m_holder[1]] = 1'b0;
      step(r, 1'b0);
    end
    // Request dropped during GRANT, then 1001 must pick 3.
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b1001, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b0);
    // Handover dead-time: owner 2 drops with 1 pending.
    step(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b0);
    step(4'b0110, 1'b0);
    step(4'b0110, 1'b0);
    for (int i = 0; i < 12; i++) step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    // Reset mid-OWN, then 1010 must grant 1.
    step(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1000, 1'b0);
    step(4'b1010, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b1010, 1'b0);
    // Lone persistent requester (forced release when the timeout is built).
    step(4'b0000, 1'b1);
    for (int i = 0; i < 60; i++) step(4'b0001, 1'b0);
    // Random traffic with occasional resets.
    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(4) == 0) r[b] = ~r[b];
      step(r, ($urandom_range(199) == 0));
    end
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0",
               exp_q0.size() + exp_q1.size() + exp_q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/la_tbuf_arb.md
Name: la_tbuf_arb

Overview:
- Arbiter/sequencer for a shared tristate net driven by N la_tbuf instances, one per requester.
- Grants ownership round-robin and drives the one-hot oe vector into the tbuf array.
- Enforces a programmable dead-time, with all oe low, between successive owners to prevent drive contention.
- Sits beside the tbuf bank in aux/pad logic; the requester side uses a simple req/gnt level handshake.

Parameters:
- N, 4, number of requesters/tbuf drivers; legal range 2..32.
- TURN, 1, turnaround dead cycles after an owner releases; legal range 0..15.
- MAXHOLD, 16, max OWN-state cycles before forced release; used only with LA_TBUF_ARB_TIMEOUT_EN; legal range 2..65535.
- PROP, "DEFAULT", implementation property string; passed through and has no functional effect.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  N  per-requester level request; held high for the duration of use.
- gnt  output  N  one-hot (or zero) grant; registered.
- oe  output  N  one-hot (or zero) tbuf output enable; registered; oe[i] implies gnt[i].
- owner  output  $clog2(N)  index of current/last grantee; registered.
- busy  output  1  high when the state is not IDLE.
- tout  output  1  one-cycle pulse on forced release; constant 0 without the macro.

Behaviour:
- Reset state, next edge after rst=1 regardless of current state:
  - state=IDLE.
  - gnt=0, oe=0, owner=0, busy=0, tout=0.
  - Round-robin pointer ptr=0; hold counter=0.
- States: IDLE, GRANT, OWN, TURN.
- IDLE:
  - If req!=0, select the first set bit searching ptr, ptr+1, …, wrapping mod N.
  - Next cycle: gnt[sel]=1, oe=0, owner=sel, ptr=(sel+1) mod N, state→GRANT.
  - If req==0, stay in IDLE.
- GRANT (one cycle; gnt gives the driver a setup cycle before oe):
  - If req[owner]=1: oe[owner]=1 next cycle, state→OWN.
  - If req[owner]=0: gnt=0 next cycle, state→IDLE with no TURN, since the bus was never driven.
- OWN:
  - gnt and oe stay asserted while req[owner]=1.
  - When req[owner]=0 is sampled: gnt=0 and oe=0 next cycle.
  - Then state→TURN if TURN>0, else →IDLE.
- TURN:
  - Counter loads TURN−1 on entry and decrements each cycle; at 0, state→IDLE.
  - Requests are ignored in TURN.
- Timing:
  - Idle-bus latency: req rising at edge k gives gnt at k+1 and oe at k+2.
  - Handover: owner drops req at edge k; oe=0 from k+1; next gnt at k+TURN+2; next oe at k+TURN+3.
  - All oe are therefore low for at least TURN+2 cycles between owners.
- Invariants:
  - oe is one-hot or zero at every cycle.
  - oe only asserts in OWN, and only for owner.
- Requests from non-owners never preempt the owner; they are only sampled in IDLE.
- Simultaneous requests are resolved strictly by ptr.
  - A releasing owner that re-requests immediately has the lowest priority on the next arbitration.
- Requesters must hold req until granted. A drop before grant is legal and simply removes the request.
- rst asserted mid-OWN forces oe=0 on the next edge; the bus is released with no dead-time guarantee beyond reset.

Optional Feature:
- Macro: LA_TBUF_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on OWN entry and increments each OWN cycle.
  - When it reaches MAXHOLD−1 with req[owner] still high, the next edge forces gnt=0, oe=0 and state→TURN (or IDLE if TURN=0), and tout pulses high for exactly that one cycle.
  - The pointer has already advanced, so other requesters win next.
  - A lone persistent requester is re-granted after the turnaround.
- Undefined:
  - No counter is built; tout is tied 0; tenure is unlimited.

Test Plan:
- Reset/idle (N=4, TURN=1): assert rst for 2 cycles with req=4'b1111 → gnt=0, oe=0, busy=0 throughout; after release, gnt=4'b0001 one cycle later and oe=4'b0001 one cycle after that.
- Round-robin order: req=4'b1111 held, each owner releases after 3 OWN cycles → grant order 0,1,2,3,0; oe low for ≥3 cycles between owners; oe never has >1 bit set.
- Dead-time with TURN=0 and TURN=3: owner 2 drops req at edge k with req[1] pending → next oe[1] rises at edge k+3 (TURN=0) and at k+6 (TURN=3).
- Drop during GRANT: req=4'b0100 for exactly 1 cycle → gnt=4'b0100 for 1 cycle, oe stays 0, return to IDLE with no TURN; ptr=3, so req=4'b1001 next selects 3.
- Reset mid-OWN: rst pulsed while oe=4'b1000 → oe=0, gnt=0, owner=0, ptr=0 on the next edge; the following arbitration with req=4'b1010 grants 1.
- Timeout (macro on, MAXHOLD=4): req[0] held high continuously, others 0 → oe[0] high for exactly 4 cycles; tout pulses 1 cycle; oe[0] reasserts after TURN+2 idle cycles. With the macro off, the same stimulus keeps oe[0] high indefinitely and tout=0.
